// File: rtl/spawn_director_if.sv
// Handshake bundle between the game controller and the spawn director.
// The director takes the slave side; the game controller or bench takes the master side.
interface spawn_director_if;
    logic        start;
    logic        tick;
    logic [3:0]  enemy_count;
    logic [3:0]  kill_count;
    logic        collision;
    logic        spawn;
    logic [5:0]  random_number;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [1:0]  game_state;

    modport master (
        output start, tick, enemy_count, kill_count, collision,
        input  spawn, random_number, score, lives, game_state
    );

    modport slave (
        input  start, tick, enemy_count, kill_count, collision,
        output spawn, random_number, score, lives, game_state
    );
endinterface

// File: rtl/spawn_director.sv
// Spawn director: game-state FSM, spawn pacing timer, scoring, lives and a free-running LFSR.
// Optional build macro DIFFICULTY_RAMP_EN shortens the spawn period as the score grows.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | after reset, waiting for start
// S_PLAY | game running, spawn timer paced by tick
// S_HIT  | player was hit, invulnerable until hit_timer expires
// S_OVER | no lives left, waiting for start
module spawn_director #(
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter logic [7:0]  SPAWN_PERIOD_MAX = 8'd120,
    parameter logic [7:0]  SPAWN_PERIOD_MIN = 8'd20,
    parameter logic [1:0]  LIVES_INIT       = 2'd3,
    parameter logic [7:0]  HIT_FRAMES       = 8'd90
) (
    input  logic               clk,
    input  logic               rst,
    spawn_director_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [15:0] score, score_nxt;
    logic [1:0]  lives, lives_nxt;
    logic [7:0]  period, period_nxt;
    logic [7:0]  spawn_timer, spawn_timer_nxt;
    logic [7:0]  hit_timer, hit_timer_nxt;
    logic        spawn_r, spawn_nxt;
    logic [16:0] score_sum;
    logic [15:0] score_add;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            score       <= 16'd0;
            lives       <= 2'd0;
            period      <= SPAWN_PERIOD_MAX;
            spawn_timer <= 8'd0;
            hit_timer   <= 8'd0;
            spawn_r     <= 1'b0;
        end else begin
            state       <= state_nxt;
            lfsr        <= lfsr_nxt;
            score       <= score_nxt;
            lives       <= lives_nxt;
            period      <= period_nxt;
            spawn_timer <= spawn_timer_nxt;
            hit_timer   <= hit_timer_nxt;
            spawn_r     <= spawn_nxt;
        end
    end

    // Galois shift right; taps never clear a nonzero register, so it cannot lock at zero.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_nxt = {1'b0, lfsr[15:1]} ^ 16'hB400;
        end
    end

    always_comb begin
        score_sum = {1'b0, score} + {13'd0, bus.kill_count};
        score_add = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_comb begin
        state_nxt       = state;
        score_nxt       = score;
        lives_nxt       = lives;
        period_nxt      = period;
        spawn_timer_nxt = spawn_timer;
        hit_timer_nxt   = hit_timer;
        spawn_nxt       = 1'b0;

        case (state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    score_nxt       = 16'd0;
                    lives_nxt       = LIVES_INIT;
                    period_nxt      = SPAWN_PERIOD_MAX;
                    spawn_timer_nxt = SPAWN_PERIOD_MAX;
                    state_nxt       = S_PLAY;
                end
            end
            S_PLAY: begin
                score_nxt = score_add;
                // A collision wins over a due spawn; the timer is reloaded on return to play.
                if (bus.collision) begin
                    if (lives <= 2'd1) begin
                        lives_nxt = 2'd0;
                        state_nxt = S_OVER;
                    end else begin
                        lives_nxt     = lives - 2'd1;
                        hit_timer_nxt = HIT_FRAMES;
                        state_nxt     = S_HIT;
                    end
                end else if (bus.tick) begin
                    if (spawn_timer != 8'd0) begin
                        spawn_timer_nxt = spawn_timer - 8'd1;
                    end else if (bus.enemy_count < 4'd8) begin
                        spawn_nxt       = 1'b1;
                        spawn_timer_nxt = period;
                    end
                end
            end
            S_HIT: begin
                score_nxt = score_add;
                if (bus.tick) begin
                    if (hit_timer == 8'd0) begin
                        spawn_timer_nxt = period;
                        state_nxt       = S_PLAY;
                    end else begin
                        hit_timer_nxt = hit_timer - 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

`ifdef DIFFICULTY_RAMP_EN
        // Every 16 points shortens the period; reloads pick up the registered value.
        if (score_nxt[15:4] > score[15:4]) begin
            if ({1'b0, period} >= ({1'b0, SPAWN_PERIOD_MIN} + 9'd4)) begin
                period_nxt = period - 8'd4;
            end else begin
                period_nxt = SPAWN_PERIOD_MIN;
            end
        end
`endif
    end

    assign bus.spawn         = spawn_r;
    assign bus.random_number = lfsr[5:0];
    assign bus.score         = score;
    assign bus.lives         = lives;
    assign bus.game_state    = state;

endmodule

// File: tb/tb_spawn_director.sv
// Directed scoreboard bench for spawn_director: expectations are queued as stimulus is
// applied and compared against the DUT one cycle later.
module tb_spawn_director;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic rst;
    spawn_director_if bus ();

    spawn_director dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {O_STATE, O_LIVES, O_SCORE, O_SPAWN, O_RAND, O_PERIOD} obs_e;
    typedef struct {
        string       tag;
        obs_e        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] lfsr_model;
    logic        spawn_q;

    // Independent LFSR reference
    always @(posedge clk) begin
        if (rst) lfsr_model = SEED;
        else     lfsr_model = lfsr_model[0] ? ({1'b0, lfsr_model[15:1]} ^ 16'hB400)
                                            : {1'b0, lfsr_model[15:1]};
    end

    always @(negedge clk) begin
        if (!rst && bus.spawn) begin
            vectors++;
            assert (spawn_q === 1'b0) else begin
                miscompares++;
                $error("FAIL spawn_back_to_back: observed %b expected 0", spawn_q);
            end
        end
        spawn_q = bus.spawn;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] observe(obs_e s);
        case (s)
            O_STATE:  return {14'd0, bus.game_state};
            O_LIVES:  return {14'd0, bus.lives};
            O_SCORE:  return bus.score;
            O_SPAWN:  return {15'd0, bus.spawn};
            O_RAND:   return {10'd0, bus.random_number};
            O_PERIOD: return {8'd0, dut.period};
            default:  return 16'hDEAD;
        endcase
    endfunction

    task automatic expect_val(input string tag, input obs_e sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [15:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic expect_rand(input string tag);
        expect_val(tag, O_RAND, {10'd0, lfsr_next6()});
    endtask

    // Random output after the coming edge, derived from the reference model
    function automatic logic [5:0] lfsr_next6();
        logic [15:0] n;
        n = lfsr_model[0] ? ({1'b0, lfsr_model[15:1]} ^ 16'hB400) : {1'b0, lfsr_model[15:1]};
        return n[5:0];
    endfunction

    task automatic play_ticks(input int n, input logic [1:0] st, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            expect_val({tag, "_state"}, O_STATE, {14'd0, st});
            expect_val({tag, "_spawn"}, O_SPAWN, 16'd0);
            cyc();
        end
        bus.tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.tick = 1'b0;
        bus.enemy_count = 4'd0;
        bus.kill_count = 4'd0;
        bus.collision = 1'b0;
        spawn_q = 1'b0;

        // Reset state
        @(posedge clk);
        expect_val("rst_state", O_STATE, 16'd0);
        expect_val("rst_lives", O_LIVES, 16'd0);
        expect_val("rst_score", O_SCORE, 16'd0);
        expect_val("rst_spawn", O_SPAWN, 16'd0);
        expect_val("rst_rand", O_RAND, {10'd0, SEED[5:0]});
        expect_val("rst_period", O_PERIOD, 16'd120);
        cyc();
        rst = 1'b0;
        expect_rand("rand_free_run");
        cyc();

        // Start: IDLE -> PLAY
        bus.start = 1'b1;
        expect_val("start_state", O_STATE, 16'd1);
        expect_val("start_lives", O_LIVES, 16'd3);
        expect_val("start_score", O_SCORE, 16'd0);
        cyc();
        bus.start = 1'b0;

        // First spawn after tick 121
        play_ticks(120, 2'd1, "pre_spawn");
        bus.tick = 1'b1;
        expect_val("first_spawn", O_SPAWN, 16'd1);
        expect_rand("rand_play");
        cyc();
        bus.tick = 1'b0;
        expect_val("first_spawn_one_cycle", O_SPAWN, 16'd0);
        cyc();

        // Full enemy array holds the due spawn
        bus.enemy_count = 4'd8;
        play_ticks(120, 2'd1, "full_count");
        play_ticks(2, 2'd1, "full_due");
        bus.enemy_count = 4'd7;
        expect_val("full_drop_no_tick", O_SPAWN, 16'd0);
        cyc();
        bus.tick = 1'b1;
        expect_val("full_release_spawn", O_SPAWN, 16'd1);
        cyc();
        bus.tick = 1'b0;
        bus.enemy_count = 4'd0;
        expect_val("full_release_one_cycle", O_SPAWN, 16'd0);
        cyc();

        // Collision with 3 lives, then one ignored during HIT
        bus.collision = 1'b1;
        expect_val("hit1_lives", O_LIVES, 16'd2);
        expect_val("hit1_state", O_STATE, 16'd2);
        cyc();
        expect_val("hit_ignore_lives", O_LIVES, 16'd2);
        expect_val("hit_ignore_state", O_STATE, 16'd2);
        cyc();
        bus.collision = 1'b0;
        bus.kill_count = 4'd3;
        expect_val("hit_kills", O_SCORE, 16'd3);
        cyc();
        bus.kill_count = 4'd0;
        play_ticks(90, 2'd2, "hit_wait");
        bus.tick = 1'b1;
        expect_val("hit_exit_state", O_STATE, 16'd1);
        cyc();
        bus.tick = 1'b0;

        // Collision and due spawn in the same cycle
        play_ticks(120, 2'd1, "coinc_pre");
        bus.tick = 1'b1;
        bus.collision = 1'b1;
        expect_val("coinc_spawn", O_SPAWN, 16'd0);
        expect_val("coinc_state", O_STATE, 16'd2);
        expect_val("coinc_lives", O_LIVES, 16'd1);
        cyc();
        bus.collision = 1'b0;
        expect_val("coinc_spawn_after", O_SPAWN, 16'd0);
        cyc();
        play_ticks(89, 2'd2, "coinc_hit");
        bus.tick = 1'b1;
        expect_val("coinc_back_play", O_STATE, 16'd1);
        cyc();
        bus.tick = 1'b0;

        // Third collision: game over, score frozen, restart
        bus.collision = 1'b1;
        expect_val("over_lives", O_LIVES, 16'd0);
        expect_val("over_state", O_STATE, 16'd3);
        cyc();
        bus.collision = 1'b0;
        bus.kill_count = 4'd5;
        play_ticks(130, 2'd3, "over_idle");
        expect_val("over_score_hold", O_SCORE, 16'd3);
        cyc();
        bus.kill_count = 4'd0;
        bus.start = 1'b1;
        expect_val("restart_state", O_STATE, 16'd1);
        expect_val("restart_score", O_SCORE, 16'd0);
        expect_val("restart_lives", O_LIVES, 16'd3);
        expect_val("restart_period", O_PERIOD, 16'd120);
        cyc();
        bus.start = 1'b0;

        // Score ramp and saturation
        bus.kill_count = 4'd8;
        cyc();
        expect_val("score_16", O_SCORE, 16'd16);
`ifdef DIFFICULTY_RAMP_EN
        expect_val("period_first_ramp", O_PERIOD, 16'd116);
`else
        expect_val("period_fixed", O_PERIOD, 16'd120);
`endif
        cyc();
        for (int i = 0; i < 8189; i++) begin
            cyc();
        end
        bus.kill_count = 4'd4;
        expect_val("score_fffc", O_SCORE, 16'hFFFC);
        cyc();
        bus.kill_count = 4'd8;
        expect_val("score_sat", O_SCORE, 16'hFFFF);
        cyc();
        expect_val("score_sat_hold", O_SCORE, 16'hFFFF);
`ifdef DIFFICULTY_RAMP_EN
        expect_val("period_floor", O_PERIOD, 16'd20);
`else
        expect_val("period_still_fixed", O_PERIOD, 16'd120);
`endif
        cyc();
        bus.kill_count = 4'd0;

        // Reset wins mid-HIT over start, tick and collision
        bus.collision = 1'b1;
        expect_val("hit_before_rst", O_STATE, 16'd2);
        cyc();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.tick = 1'b1;
        expect_val("rst_mid_state", O_STATE, 16'd0);
        expect_val("rst_mid_lives", O_LIVES, 16'd0);
        expect_val("rst_mid_score", O_SCORE, 16'd0);
        expect_val("rst_mid_spawn", O_SPAWN, 16'd0);
        expect_val("rst_mid_rand", O_RAND, {10'd0, SEED[5:0]});
        cyc();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.tick = 1'b0;
        bus.collision = 1'b0;
        expect_val("post_rst_idle", O_STATE, 16'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spawn_director.md
SPAWN_DIRECTOR -- requirements
Module: spawn_director

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero reset value of the random generator.
REQ-002 SHALL have parameter SPAWN_PERIOD_MAX, default 8'd120, initial frames between spawns.
REQ-003 SHALL have parameter SPAWN_PERIOD_MIN, default 8'd20, floor of the spawn period.
REQ-004 SHALL have parameter LIVES_INIT, default 2'd3, lives at game start.
REQ-005 SHALL have parameter HIT_FRAMES, default 8'd90, invulnerability frames after a hit.
REQ-006 SHALL have port clk input 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst input 1: synchronous, active-high reset.
REQ-008 SHALL have port start input 1: one-cycle pulse that starts or restarts a game.
REQ-009 SHALL have port tick input 1: one-cycle frame-rate pulse.
REQ-010 SHALL have port enemy_count input 4: number of live enemies, 0..8.
REQ-011 SHALL have port kill_count input 4: enemies killed in this cycle, 0..8.
REQ-012 SHALL have port collision input 1: an enemy reached the player this cycle.
REQ-013 SHALL have port spawn output 1: one-cycle spawn request to the enemy array.
REQ-014 SHALL have port random_number output 6: [3:0] spawn angle, [5:4] spawn kind.
REQ-015 SHALL have port score output 16: accumulated kills.
REQ-016 SHALL have port lives output 2: remaining lives.
REQ-017 SHALL have port game_state output 2: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.

Function
REQ-018 SHALL advance a 16-bit Galois LFSR (mask 16'hB400) every clk in all states; random_number = lfsr[5:0]; it never reaches zero.
REQ-019 SHALL, in IDLE or OVER on start, load score=0, lives=LIVES_INIT, period=SPAWN_PERIOD_MAX, spawn_timer=period and enter PLAY on the next cycle; start is ignored in PLAY and HIT.
REQ-020 SHALL, in PLAY on tick with spawn_timer>0, decrement spawn_timer by 1.
REQ-021 SHALL, in PLAY on tick with spawn_timer==0 and enemy_count<8, register spawn=1 for exactly the next cycle and reload spawn_timer=period.
REQ-022 SHALL, with spawn_timer==0 and enemy_count==8, hold spawn_timer at 0 and spawn at the first later tick where enemy_count<8.
REQ-023 SHALL add kill_count to score every cycle in PLAY and HIT, saturating at 16'hFFFF; score holds in IDLE and OVER.
REQ-024 SHALL, in PLAY when collision=1, decrement lives; if lives was 1, enter OVER with lives=0, else enter HIT with hit_timer=HIT_FRAMES.
REQ-025 SHALL, when collision and a due spawn coincide in PLAY, honour the collision and suppress that spawn; spawn_timer reloads on return to PLAY.
REQ-026 SHALL, in HIT, drive spawn=0, ignore collision, decrement hit_timer on tick, and enter PLAY with spawn_timer=period when hit_timer is 0 on a tick.
REQ-027 SHALL drive spawn=0 in IDLE, HIT and OVER; spawn is never high on two consecutive cycles.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set game_state=IDLE, spawn=0, score=0, lives=0, lfsr=LFSR_SEED, spawn_timer=0, hit_timer=0, period=SPAWN_PERIOD_MAX.
REQ-029 SHALL give rst priority over start, tick and collision, including mid-game and mid-HIT.

Configuration
REQ-030 SHALL, with DIFFICULTY_RAMP_EN defined, reduce period by 4 each cycle that score[15:4] increases, clamped at SPAWN_PERIOD_MIN; the new period takes effect at the next reload.
REQ-031 SHALL, without DIFFICULTY_RAMP_EN, keep period fixed at SPAWN_PERIOD_MAX.

Verification
REQ-032 SHALL test reset then start: game_state 0->1, lives=3, score=0; the first spawn pulse appears after tick 121, spawn high exactly 1 cycle.
REQ-033 SHALL test enemy_count=8 held through the due tick: no spawn; enemy_count drops to 7, then spawn on the next tick.
REQ-034 SHALL test collision in PLAY with lives=3: lives=2, state=HIT; a second collision during HIT leaves lives=2; after 91 ticks state=PLAY.
REQ-035 SHALL test a third collision: lives 1->0, state=OVER, spawn stays 0; start returns to PLAY with score=0 and lives=3.
REQ-036 SHALL test score saturation: score preloaded to 16'hFFFC via kills, kill_count=8 gives score=16'hFFFF; with DIFFICULTY_RAMP_EN, crossing score 16 gives period=116, and repeated crossings floor at period=20.
REQ-037 SHALL test collision and a due spawn in the same cycle: no spawn, state=HIT.
